// File: rtl/pong_ball_ctrl.sv
// Pong ball controller: per-frame ball motion, paddle and wall bounces,
// scoring, serve delay and the game-over / restart sequence.
module pong_ball_ctrl #(
  parameter int h_video       = 640,
  parameter int v_video       = 480,
  parameter int square_width  = 16,
  parameter int paddle_width  = 12,
  parameter int paddle_height = 96,
  parameter int speed_x       = 4,
  parameter int speed_y       = 2,
  parameter int win_score     = 9,
  parameter int serve_delay   = 60
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic [9:0] paddle1_xpos,
  input  logic [9:0] paddle1_ypos,
  input  logic [9:0] paddle2_xpos,
  input  logic [9:0] paddle2_ypos,
  output logic [9:0] square_xpos,
  output logic [9:0] square_ypos,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       point_p1,
  output logic       point_p2,
  output logic [1:0] game_state
);

  localparam int               CNT_W    = ($clog2(serve_delay) > 6) ? $clog2(serve_delay) : 6;
  localparam logic [11:0]      X_MAX    = 12'(h_video - 1 - square_width);
  localparam logic [11:0]      Y_MAX    = 12'(v_video - 1 - square_width);
  localparam logic [9:0]       X_CTR    = 10'((h_video - square_width) / 2);
  localparam logic [9:0]       Y_CTR    = 10'((v_video - square_width) / 2);
  localparam logic [11:0]      SQ_W     = 12'(square_width);
  localparam logic [11:0]      SPD_X    = 12'(speed_x);
  localparam logic [11:0]      SPD_Y    = 12'(speed_y);
  localparam logic [3:0]       WIN      = 4'(win_score);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(serve_delay - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_PLAY   = 2'b01,
    ST_SCORED = 2'b10,
    ST_OVER   = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       score1_q, score1_d, score2_q, score2_d;
  logic             point_p1_q, point_p1_d, point_p2_q, point_p2_d;

  // Edge geometry is evaluated in 12 bits so sums near the right/bottom edge cannot wrap.
  logic [11:0] x_w, y_w, p1r_w, p2x_w, bre_w;
  logic        hit_l, hit_r;

  function automatic logic v_overlap(input logic [11:0] ball_y, input logic [9:0] pad_y);
    logic [11:0] pad_w;
    pad_w = {2'b00, pad_y};
    return (ball_y + SQ_W >= pad_w) && (ball_y <= pad_w + 12'(paddle_height));
  endfunction

  assign x_w   = {2'b00, x_q};
  assign y_w   = {2'b00, y_q};
  assign p1r_w = {2'b00, paddle1_xpos} + 12'(paddle_width);
  assign p2x_w = {2'b00, paddle2_xpos};
  assign bre_w = x_w + SQ_W;
  assign hit_l = (x_w > p1r_w) && (x_w <= p1r_w + SPD_X) && v_overlap(y_w, paddle1_ypos);
  assign hit_r = (bre_w < p2x_w) && (bre_w + SPD_X >= p2x_w) && v_overlap(y_w, paddle2_ypos);

  logic goal_p1, goal_p2;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    dir_x_d    = dir_x_q;
    dir_y_d    = dir_y_q;
    cnt_d      = cnt_q;
    score1_d   = score1_q;
    score2_d   = score2_q;
    point_p1_d = 1'b0;
    point_p2_d = 1'b0;
    goal_p1    = 1'b0;
    goal_p2    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        x_d = X_CTR;
        y_d = Y_CTR;
        if (serve) state_d = ST_PLAY;
      end

      ST_PLAY: begin
        if (frame_tick) begin
          if (dir_y_q) begin
            if (y_w + SPD_Y >= Y_MAX) begin
              y_d     = Y_MAX[9:0];
              dir_y_d = 1'b0;
            end else begin
              y_d = y_q + SPD_Y[9:0];
            end
          end else if (y_w <= SPD_Y) begin
            y_d     = 10'd0;
            dir_y_d = 1'b1;
          end else begin
            y_d = y_q - SPD_Y[9:0];
          end

          if (!dir_x_q) begin
            if (hit_l) begin
              x_d     = p1r_w[9:0] + 10'd1;
              dir_x_d = 1'b1;
            end else if (x_w < SPD_X) begin
              goal_p2 = 1'b1;
            end else begin
              x_d = x_q - SPD_X[9:0];
            end
          end else begin
            if (hit_r) begin
              x_d     = paddle2_xpos - 10'(square_width + 1);
              dir_x_d = 1'b0;
            end else if (x_w + SPD_X > X_MAX) begin
              goal_p1 = 1'b1;
            end else begin
              x_d = x_q + SPD_X[9:0];
            end
          end

          // A point overrides the position; the re-serve heads toward the player who conceded.
          if (goal_p1 || goal_p2) begin
            x_d     = X_CTR;
            y_d     = Y_CTR;
            cnt_d   = '0;
            dir_x_d = goal_p1;
            if (goal_p1) begin
              score1_d   = (score1_q < WIN) ? score1_q + 4'd1 : score1_q;
              point_p1_d = 1'b1;
              state_d    = (score1_d == WIN) ? ST_OVER : ST_SCORED;
            end else begin
              score2_d   = (score2_q < WIN) ? score2_q + 4'd1 : score2_q;
              point_p2_d = 1'b1;
              state_d    = (score2_d == WIN) ? ST_OVER : ST_SCORED;
            end
          end
        end
      end

      ST_SCORED: begin
        x_d = X_CTR;
        y_d = Y_CTR;
        if (frame_tick) begin
          if (cnt_q == CNT_LAST) state_d = ST_PLAY;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end

      ST_OVER: begin
        x_d = X_CTR;
        y_d = Y_CTR;
        if (serve) begin
          score1_d = 4'd0;
          score2_d = 4'd0;
          state_d  = ST_IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      x_q        <= X_CTR;
      y_q        <= Y_CTR;
      dir_x_q    <= 1'b1;
      dir_y_q    <= 1'b1;
      cnt_q      <= '0;
      score1_q   <= 4'd0;
      score2_q   <= 4'd0;
      point_p1_q <= 1'b0;
      point_p2_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      cnt_q      <= cnt_d;
      score1_q   <= score1_d;
      score2_q   <= score2_d;
      point_p1_q <= point_p1_d;
      point_p2_q <= point_p2_d;
    end
  end

  assign square_xpos = x_q;
  assign square_ypos = y_q;
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign point_p1    = point_p1_q;
  assign point_p2    = point_p2_q;
  assign game_state  = state_q;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Bench for pong_ball_ctrl: directed bounce/score/reset scenarios and randomized
// rallies, every cycle compared against a frame-level arithmetic model.
module tb_pong_ball_ctrl;

  localparam int SQ = 16, PW = 12, PH = 96, SX = 4, SY = 2, WIN = 9, DELAY = 60;
  localparam int X_MAX = 623, Y_MAX = 463, X_C = 312, Y_C = 232;
  localparam int S_IDLE = 0, S_PLAY = 1, S_SCORED = 2, S_OVER = 3;

  logic       clk_0 = 1'b0;
  logic       rst = 1'b0, frame_tick = 1'b0, serve = 1'b0;
  logic [9:0] p1x = 10'd16, p1y = 10'd0, p2x = 10'd351, p2y = 10'd0;
  logic [9:0] square_xpos, square_ypos;
  logic [3:0] score1, score2;
  logic       point_p1, point_p2;
  logic [1:0] game_state;

  pong_ball_ctrl dut (
    .clk_0        (clk_0),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .serve        (serve),
    .paddle1_xpos (p1x),
    .paddle1_ypos (p1y),
    .paddle2_xpos (p2x),
    .paddle2_ypos (p2y),
    .square_xpos  (square_xpos),
    .square_ypos  (square_ypos),
    .score1       (score1),
    .score2       (score2),
    .point_p1     (point_p1),
    .point_p2     (point_p2),
    .game_state   (game_state)
  );

  always #20 clk_0 = ~clk_0;

  int checks = 0, errors = 0;
  int m_state, m_x, m_y, m_dx, m_dy, m_cnt, m_s1, m_s2, m_pp1, m_pp2;
  int bot_pending = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "/x"},     32'(square_xpos), m_x);
    check({tag, "/y"},     32'(square_ypos), m_y);
    check({tag, "/s1"},    32'(score1), m_s1);
    check({tag, "/s2"},    32'(score2), m_s2);
    check({tag, "/pp1"},   32'(point_p1), m_pp1);
    check({tag, "/pp2"},   32'(point_p2), m_pp2);
    check({tag, "/state"}, 32'(game_state), m_state);
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_x = X_C; m_y = Y_C; m_dx = 1; m_dy = 1;
    m_cnt = 0; m_s1 = 0; m_s2 = 0; m_pp1 = 0; m_pp2 = 0;
  endtask

  function automatic bit m_overlap(input int by, input int py);
    return (by + SQ >= py) && (by <= py + PH);
  endfunction

  // One clock of the game rules, using the paddle values presented on that edge.
  task automatic model_cycle(input bit t, input bit s);
    int nx, ny, p1r, bre;
    bit sc1, sc2;
    m_pp1 = 0; m_pp2 = 0;
    sc1 = 0; sc2 = 0;
    if (m_state == S_IDLE) begin
      if (s) m_state = S_PLAY;
    end else if (m_state == S_OVER) begin
      if (s) begin m_s1 = 0; m_s2 = 0; m_state = S_IDLE; end
    end else if (m_state == S_SCORED) begin
      if (t) begin
        if (m_cnt == DELAY - 1) m_state = S_PLAY;
        else m_cnt++;
      end
    end else if (t) begin
      ny = (m_dy == 1) ? m_y + SY : m_y - SY;
      if (m_dy == 1 && ny >= Y_MAX) begin ny = Y_MAX; m_dy = 0; end
      else if (m_dy == 0 && m_y <= SY) begin ny = 0; m_dy = 1; end
      if (m_dx == 0) begin
        p1r = int'(p1x) + PW;
        nx  = m_x - SX;
        if (m_x > p1r && nx <= p1r && m_overlap(m_y, int'(p1y))) begin
          nx = p1r + 1; m_dx = 1;
        end else if (nx < 0) sc2 = 1;
      end else begin
        bre = m_x + SQ;
        nx  = m_x + SX;
        if (bre < int'(p2x) && bre + SX >= int'(p2x) && m_overlap(m_y, int'(p2y))) begin
          nx = int'(p2x) - SQ - 1; m_dx = 0;
        end else if (nx > X_MAX) sc1 = 1;
      end
      if (sc1 || sc2) begin
        nx = X_C; ny = Y_C; m_cnt = 0;
        if (sc1) begin m_s1++; m_pp1 = 1; m_dx = 1; end
        else     begin m_s2++; m_pp2 = 1; m_dx = 0; end
        m_state = (m_s1 == WIN || m_s2 == WIN) ? S_OVER : S_SCORED;
      end
      m_x = nx; m_y = ny;
    end
  endtask

  task automatic step(input bit t, input bit s, input string tag);
    frame_tick = t;
    serve      = s;
    @(posedge clk_0);
    #1;
    frame_tick = 1'b0;
    serve      = 1'b0;
    model_cycle(t, s);
    compare_all(tag);
  endtask

  // Frame tick plus explicit checks around a bottom-wall bounce.
  task automatic frame(input bit s, input string tag);
    bit was_down;
    was_down = (m_state == S_PLAY) && (m_dy == 1);
    step(1'b1, s, tag);
    if (bot_pending == 1 && m_pp1 == 0 && m_pp2 == 0)
      check("after_bottom_y", 32'(square_ypos), 461);
    bot_pending = 0;
    if (was_down && m_dy == 0 && m_pp1 == 0 && m_pp2 == 0) begin
      check("bottom_y", 32'(square_ypos), Y_MAX);
      bot_pending = 1;
    end
  endtask

  function automatic int track_y(input int by);
    return (by >= 40) ? by - 40 : 0;
  endfunction

  function automatic int avoid_y(input int by);
    return (by >= 120) ? by - 100 : by + 20;
  endfunction

  task automatic rally(input int p1_pct, input int p2_pct, input string tag);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 4000 && !done; n++) begin
      p1y = 10'((int'($urandom_range(0, 99)) < p1_pct) ? track_y(m_y) : avoid_y(m_y));
      p2y = 10'((int'($urandom_range(0, 99)) < p2_pct) ? track_y(m_y) : avoid_y(m_y));
      repeat (int'($urandom_range(0, 2))) step(1'b0, $urandom_range(0, 3) == 0, tag);
      frame($urandom_range(0, 3) == 0, tag);
      done = (m_pp1 == 1) || (m_pp2 == 1);
    end
    check({tag, "/rally_end"}, 32'(done), 1);
  endtask

  task automatic wait_scored(input string tag);
    bit done;
    done = 1'b0;
    p1x = 10'($urandom_range(0, 40));
    p2x = 10'($urandom_range(560, 620));
    for (int n = 0; n < 200 && !done; n++) begin
      repeat (int'($urandom_range(0, 2))) step(1'b0, $urandom_range(0, 1) == 1, tag);
      frame($urandom_range(0, 1) == 1, tag);
      done = (m_state == S_PLAY);
    end
    check({tag, "/replay"}, 32'(done), 1);
  endtask

  initial begin
    model_reset();
    #5 rst = 1'b1;
    #1 compare_all("rst_async_initial");
    #30 rst = 1'b0;
    @(posedge clk_0);
    #1 compare_all("idle_after_rst");

    // Serve, first movement and the paddle2 bounce setup.
    step(1'b0, 1'b1, "serve");
    check("serve_state", 32'(game_state), S_PLAY);
    p2y = 10'(track_y(m_y));
    frame(1'b0, "first_tick");
    check("first_x", 32'(square_xpos), 316);
    check("first_y", 32'(square_ypos), 234);

    for (int n = 0; n < 200 && m_dx == 1; n++) begin
      p2y = 10'(track_y(m_y)); p1y = 10'(avoid_y(m_y));
      frame(1'b0, "to_p2a");
    end
    check("p2_bounce_a", 32'(square_xpos), 334);
    for (int n = 0; n < 200 && m_x != 30; n++) begin
      p1y = 10'(avoid_y(m_y));
      frame(1'b0, "to_30a");
    end
    p1y = 10'(track_y(m_y));
    frame(1'b0, "p1_hit");
    check("p1_hit_x", 32'(square_xpos), 29);

    for (int n = 0; n < 200 && m_dx == 1; n++) begin
      p2y = 10'(track_y(m_y));
      frame(1'b0, "to_p2b");
    end
    check("p2_bounce_b", 32'(square_xpos), 334);
    for (int n = 0; n < 200 && m_x != 30; n++) begin
      p1y = 10'(avoid_y(m_y));
      frame(1'b0, "to_30b");
    end
    p1y = 10'(avoid_y(m_y));
    frame(1'b0, "p1_miss");
    check("p1_miss_x", 32'(square_xpos), 26);

    for (int n = 0; n < 20 && m_pp2 == 0; n++) begin
      p1y = 10'(avoid_y(m_y));
      frame(1'b0, "to_left_wall");
    end
    check("p2_point_pulse", 32'(point_p2), 1);
    check("p2_point_score", 32'(score2), 1);
    check("p2_point_x", 32'(square_xpos), X_C);
    check("p2_point_y", 32'(square_ypos), Y_C);
    check("p2_point_state", 32'(game_state), S_SCORED);
    step(1'b0, 1'b0, "pulse_drop");
    check("p2_pulse_one_cycle", 32'(point_p2), 0);

    for (int i = 0; i < DELAY - 1; i++) frame($urandom_range(0, 1) == 1, "scored_hold");
    check("still_scored", 32'(game_state), S_SCORED);
    frame(1'b0, "delay_end");
    check("delay_end_state", 32'(game_state), S_PLAY);
    check("delay_end_x", 32'(square_xpos), X_C);
    frame(1'b0, "first_after_point");
    check("first_after_point_x", 32'(square_xpos), 308);

    // Randomized rallies: player 1 never misses, so only score1 climbs.
    for (int k = 0; k < 20 && m_s1 < WIN - 1; k++) begin
      rally(100, 30, "p1_rally");
      if (m_state == S_SCORED) wait_scored("p1_wait");
    end
    check("score1_eight", 32'(score1), 8);
    rally(100, 0, "final_rally");
    check("final_score1", 32'(score1), 9);
    check("final_state", 32'(game_state), S_OVER);
    check("final_pulse", 32'(point_p1), 1);
    for (int i = 0; i < 3; i++) frame(1'b0, "over_ticks");
    check("over_frozen_s1", 32'(score1), 9);
    check("over_frozen_x", 32'(square_xpos), X_C);

    step(1'b1, 1'b1, "over_serve");
    check("restart_s1", 32'(score1), 0);
    check("restart_s2", 32'(score2), 0);
    check("restart_state", 32'(game_state), S_IDLE);
    step(1'b1, 1'b1, "idle_serve_tick");
    check("idle_serve_tick_x", 32'(square_xpos), X_C);
    check("idle_serve_tick_state", 32'(game_state), S_PLAY);
    frame(1'b1, "play_serve_ignored");
    check("play_serve_x", 32'(square_xpos), 316);

    // Reset mid-PLAY.
    for (int i = 0; i < 3; i++) frame(1'b0, "pre_rst_play");
    #10 rst = 1'b1;
    #1 model_reset();
    compare_all("rst_mid_play");
    @(posedge clk_0);
    #1 compare_all("rst_held");
    #10 rst = 1'b0;

    // Reset mid-SCORED, then a tick with no serve must not move the ball.
    step(1'b0, 1'b1, "serve_again");
    rally(60, 60, "mixed_rally");
    for (int i = 0; i < 5; i++) frame(1'b0, "pre_rst_scored");
    check("pre_rst_state", 32'(game_state), S_SCORED);
    #10 rst = 1'b1;
    #1 model_reset();
    compare_all("rst_mid_scored");
    @(posedge clk_0);
    #10 rst = 1'b0;
    step(1'b1, 1'b0, "post_rst_tick");
    check("post_rst_state", 32'(game_state), S_IDLE);
    check("post_rst_x", 32'(square_xpos), X_C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
